// File: rtl/simprisc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | simprisc_pkg : shared types and constants for the simprisc core    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package simprisc_pkg;

    localparam int XLEN_C = 32;

    typedef logic [31:0] instr_t;

    typedef struct packed {
        instr_t pc;
        instr_t instr;
    } ifq_entry_t;

    localparam int          PC_STEP  = 4;
    localparam logic [1:0]  RVC_MASK = 2'b11;

    // Anything whose low two bits are not 2'b11 is not a 32-bit encoding.
    function automatic logic is_illegal(input instr_t instr);
        return (instr[1:0] != RVC_MASK);
    endfunction

endpackage
`default_nettype wire

// File: rtl/simprisc_ifq_mem.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | simprisc_ifq_mem : entry storage, one write port, async read port  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module simprisc_ifq_mem
    import simprisc_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  ifq_entry_t        i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output ifq_entry_t        o_rdata
);

    // Data array carries no reset; the owner masks reads with its valid flag.
    ifq_entry_t r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/simprisc_ifq.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | simprisc_ifq : in-order instruction fetch queue with flush,        |
// |                illegal-encoding flag and PC sequence checker       |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module simprisc_ifq
    import simprisc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [XLEN-1:0]            in_pc,
    input  logic [XLEN-1:0]            in_instr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_pc,
    output logic [XLEN-1:0]            out_instr,
    output logic                       out_illegal,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       seq_err
);

    localparam int                c_PTR_W  = $clog2(DEPTH);
    localparam int                c_CNT_W  = $clog2(DEPTH+1);
    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_CNT_1 = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_1 = c_PTR_W'(1);
    localparam logic [XLEN-1:0]    c_STEP  = XLEN'(PC_STEP);

    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_pc_track_valid;
    logic [XLEN-1:0]    r_last_pc;
    logic               r_seq_err;

    logic       w_push;
    logic       w_pop;
    logic       w_seq_break;
    ifq_entry_t w_wdata;
    ifq_entry_t w_head;

    // Both handshake flags depend only on registered occupancy.
    assign in_ready  = (r_count != c_FULL);
    assign out_valid = (r_count != '0);

    assign w_push      = in_valid && in_ready && !flush;
    assign w_pop       = out_valid && out_ready && !flush;
    assign w_seq_break = r_pc_track_valid && (in_pc != r_last_pc + c_STEP);

    assign w_wdata.pc    = in_pc;
    assign w_wdata.instr = in_instr;

    simprisc_ifq_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (c_PTR_W)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wdata),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_head)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr         <= '0;
            r_wr_ptr         <= '0;
            r_count          <= '0;
            r_pc_track_valid <= 1'b0;
            r_last_pc        <= '0;
            r_seq_err        <= 1'b0;
        end else begin
            r_seq_err <= w_push && w_seq_break;
            if (flush) begin
                r_rd_ptr         <= '0;
                r_wr_ptr         <= '0;
                r_count          <= '0;
                r_pc_track_valid <= 1'b0;
            end else begin
                if (w_push) begin
                    r_wr_ptr         <= r_wr_ptr + c_PTR_1;
                    r_last_pc        <= in_pc;
                    r_pc_track_valid <= 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_PTR_1;
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + c_CNT_1;
                end else if (w_pop && !w_push) begin
                    r_count <= r_count - c_CNT_1;
                end
            end
        end
    end

    // Stale array contents never leak out while the queue is empty.
    assign out_pc      = out_valid ? w_head.pc    : '0;
    assign out_instr   = out_valid ? w_head.instr : '0;
    assign out_illegal = out_valid && is_illegal(w_head.instr);
    assign count       = r_count;
    assign seq_err     = r_seq_err;

endmodule
`default_nettype wire

// File: tb/tb_simprisc_ifq.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_simprisc_ifq : directed bench with a queue-based reference model |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_simprisc_ifq;
    import simprisc_pkg::*;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_instr;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_instr;
    logic            out_illegal;
    logic            flush;
    logic [2:0]      count;
    logic            seq_err;

    int n_checks = 0;
    int n_err    = 0;

    simprisc_ifq #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_pc       (in_pc),
        .in_instr    (in_instr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_instr   (out_instr),
        .out_illegal (out_illegal),
        .flush       (flush),
        .count       (count),
        .seq_err     (seq_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain FIFO of entries plus the last pushed PC.
    ifq_entry_t    mq[$];
    logic          m_track;
    logic [31:0]   m_last;
    logic          m_seq;
    bit            m_push;
    bit            m_pop;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_track = 1'b0;
            m_last  = '0;
            m_seq   = 1'b0;
        end else begin
            m_push = in_valid && (mq.size() != DEPTH) && !flush;
            m_pop  = (mq.size() != 0) && out_ready && !flush;
            m_seq  = m_push && m_track && (in_pc != m_last + 32'd4);
            if (flush) begin
                mq.delete();
                m_track = 1'b0;
            end else begin
                if (m_pop) void'(mq.pop_front());
                if (m_push) begin
                    mq.push_back('{pc: in_pc, instr: in_instr});
                    m_track = 1'b1;
                    m_last  = in_pc;
                end
            end
        end
    end

    ifq_entry_t c_head;
    bit         c_val;

    always @(negedge clk) begin
        c_val  = (mq.size() != 0);
        c_head = c_val ? mq[0] : '0;
        chk("in_ready",    in_ready,    mq.size() != DEPTH);
        chk("out_valid",   out_valid,   c_val);
        chk("out_pc",      out_pc,      c_head.pc);
        chk("out_instr",   out_instr,   c_head.instr);
        chk("out_illegal", out_illegal, c_val && (c_head.instr[1:0] != 2'b11));
        chk("count",       count,       mq.size());
        chk("seq_err",     seq_err,     m_seq);
    end

    // Apply one cycle of inputs, then return just after the rising edge.
    task automatic cyc(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic ordy, input logic fl);
        in_valid  = v;
        in_pc     = pc;
        in_instr  = ins;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_pc = '0; in_instr = '0;
        out_ready = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready",  in_ready,  1'b1);
        chk("rst_count",     count,     3'd0);
        chk("rst_out_pc",    out_pc,    32'h0);
        rst = 1'b0;

        // Fill then drain
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'(i * 4), 32'h13 | 32'(i << 8), 1'b0, 1'b0);
        chk("fill_count",    count,    3'd4);
        chk("fill_in_ready", in_ready, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("drain_pc", out_pc, 32'(i * 4));
            cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        end
        chk("drain_count", count, 3'd0);

        // Steady push/pop at count 2, pointers wrap several times
        cyc(1'b1, 32'h10, 32'h0000_0093, 1'b0, 1'b0);
        cyc(1'b1, 32'h14, 32'h0000_0113, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            chk("pp_head", out_pc, 32'h10 + 32'(i * 4));
            cyc(1'b1, 32'h18 + 32'(i * 4), 32'h0000_0013, 1'b1, 1'b0);
            chk("pp_count", count, 3'd2);
        end
        repeat (2) cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Flush with count 3 and a valid input in the same cycle
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'h40 + 32'(i * 4), 32'h13, 1'b0, 1'b0);
        cyc(1'b1, 32'h4C, 32'h13, 1'b0, 1'b1);
        chk("flush_count", count,     3'd0);
        chk("flush_valid", out_valid, 1'b0);
        cyc(1'b1, 32'h100, 32'h13, 1'b0, 1'b0);
        chk("post_flush_seq", seq_err, 1'b0);
        chk("post_flush_pc",  out_pc,  32'h100);

        // Discontinuity and wrap
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        cyc(1'b1, 32'h10, 32'h13, 1'b0, 1'b0);
        chk("disc_first", seq_err, 1'b0);
        cyc(1'b1, 32'h20, 32'h13, 1'b0, 1'b0);
        chk("disc_pulse", seq_err, 1'b1);
        idle();
        chk("disc_clear", seq_err, 1'b0);
        cyc(1'b1, 32'hFFFF_FFFC, 32'h13, 1'b0, 1'b0);
        cyc(1'b1, 32'h0, 32'h13, 1'b0, 1'b0);
        chk("wrap_seq", seq_err, 1'b0);
        chk("wrap_full", in_ready, 1'b0);

        // Illegal flag
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        cyc(1'b1, 32'h200, 32'h0000_4501, 1'b0, 1'b0);
        chk("illegal_rvc", out_illegal, 1'b1);
        cyc(1'b1, 32'h204, 32'h0000_0013, 1'b1, 1'b0);
        chk("illegal_addi", out_illegal, 1'b0);
        chk("illegal_pc",   out_pc,      32'h204);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Async reset mid-drain at count 3
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'h300 + 32'(i * 4), 32'h13, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("pre_rst_count", count, 3'd3);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", out_valid, 1'b0);
        chk("arst_in_ready",  in_ready,  1'b1);
        chk("arst_count",     count,     3'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle();
        idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
